// File: rtl/uart_pkg.sv
// Shared UART TX definitions: sequencer state encoding, line-mux select codes and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of the payload; odd type inverts the even result. Zero latency, no flow control.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par_bit
);

  assign o_par_bit = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Frame sequencer: accepts a payload, walks START/DATA/PARITY/STOP and drives the line mux and busy.
// Accepts in IDLE or STOP (back-to-back, no gap); DATA_VALID is ignored mid-frame, so upstream holds it.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [1:0]            mux_sel,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_err
);

  tx_state_e r_state;
  tx_state_e w_next_state;
  logic      r_par_en;
  logic      r_par_bit;
  logic      r_frame_err;
  logic      w_accept;
  logic      w_par_bit;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (P_DATA),
    .i_par_typ(PAR_TYP),
    .o_par_bit(w_par_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= w_par_bit;
      end
      // A serializer still reporting done while START is on the line missed our load pulse.
      if (r_state == ST_START && ser_done) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    mux_sel      = MUX_STOP;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (DATA_VALID) begin
          w_accept     = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        mux_sel      = MUX_START;
        busy         = 1'b1;
        w_next_state = ST_DATA;
      end
      ST_DATA: begin
        mux_sel = MUX_DATA;
        busy    = 1'b1;
        if (ser_done) begin
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        mux_sel      = MUX_PAR;
        busy         = 1'b1;
        w_next_state = ST_STOP;
      end
      ST_STOP: begin
        busy = 1'b1;
        if (DATA_VALID) begin
          w_accept     = 1'b1;
          w_next_state = ST_START;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Select decodes from the registered state, so reset forces the stop/idle level without passing 0.
  always_comb begin
    TX_OUT = 1'b1;
    case (mux_sel)
      MUX_START: TX_OUT = 1'b0;
      MUX_STOP:  TX_OUT = 1'b1;
      MUX_DATA:  TX_OUT = ser_data;
      MUX_PAR:   TX_OUT = r_par_bit;
      default:   TX_OUT = 1'b1;
    endcase
  end

  assign ser_en    = w_accept;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level queue model compared every cycle, plus literal frame traces.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic       tx;
    logic       bsy;
    logic [1:0] mux;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b1, bsy: 1'b0, mux: 2'b01};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       force_done = 1'b0;
  logic       ser_done, ser_data, ser_en, tx_out, busy, frame_err;
  logic [1:0] mux_sel;

  logic       dv5 = 1'b0;
  logic [4:0] pdata5 = 5'h00;
  logic       par_en5 = 1'b0;
  logic       par_typ5 = 1'b0;
  logic       ser_done5, ser_data5, ser_en5, tx5, busy5, ferr5;
  logic [1:0] mux5;

  int   n_checks = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic m_err = 1'b0;
  logic last_tx, last_busy, last_acc, last5_tx;
  int   par_cnt, sen_cnt, d5_cnt, b5_cnt;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(clk), .RST(rst_n), .DATA_VALID(dv), .P_DATA(pdata), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .ser_done(ser_done), .ser_data(ser_data), .ser_en(ser_en), .mux_sel(mux_sel), .TX_OUT(tx_out),
    .busy(busy), .frame_err(frame_err)
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst_n), .DATA_VALID(dv5), .P_DATA(pdata5), .PAR_EN(par_en5), .PAR_TYP(par_typ5),
    .ser_done(ser_done5), .ser_data(ser_data5), .ser_en(ser_en5), .mux_sel(mux5), .TX_OUT(tx5),
    .busy(busy5), .frame_err(ferr5)
  );

  // Serializer stand-ins: load on ser_en, one idle START slot, then W bits LSB first, done on the last.
  logic [7:0] s_sh;
  logic [3:0] s_rem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sh  <= '0;
      s_rem <= '0;
    end else if (ser_en) begin
      s_sh  <= pdata;
      s_rem <= 4'd9;
    end else if (s_rem != 4'd0) begin
      s_rem <= s_rem - 4'd1;
    end
  end
  assign ser_done = force_done | (s_rem <= 4'd1);
  assign ser_data = (s_rem != 4'd0 && s_rem <= 4'd8) ? s_sh[3'(4'd8 - s_rem)] : 1'b1;

  logic [4:0] s5_sh;
  logic [3:0] s5_rem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s5_sh  <= '0;
      s5_rem <= '0;
    end else if (ser_en5) begin
      s5_sh  <= pdata5;
      s5_rem <= 4'd6;
    end else if (s5_rem != 4'd0) begin
      s5_rem <= s5_rem - 4'd1;
    end
  end
  assign ser_done5 = (s5_rem <= 4'd1);
  assign ser_data5 = (s5_rem != 4'd0 && s5_rem <= 4'd5) ? s5_sh[3'(4'd5 - s5_rem)] : 1'b1;

  task automatic chkv(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkv(name, 16'(act), 16'(exp));
  endtask

  // One clock cycle: compare outputs against the frame model at negedge, then return at posedge+1.
  task automatic cycle();
    exp_t cur;
    logic idle_now;
    logic acc;
    @(negedge clk);
    idle_now = (exp_q.size() == 0);
    cur = idle_now ? IDLE_E : exp_q.pop_front();
    acc = dv && (idle_now || cur.mux == 2'b01);
    chk1("tx_out", tx_out, cur.tx);
    chk1("busy", busy, cur.bsy);
    chkv("mux_sel", 16'(mux_sel), 16'(cur.mux));
    chk1("ser_en", ser_en, acc);
    chk1("frame_err", frame_err, m_err);
    if (!idle_now && cur.mux == 2'b00 && force_done) m_err = 1'b1;
    last_tx   = tx_out;
    last_busy = busy;
    last_acc  = acc;
    last5_tx  = tx5;
    if (mux_sel == 2'b11) par_cnt++;
    if (ser_en) sen_cnt++;
    if (mux5 == 2'b10) d5_cnt++;
    if (busy5) b5_cnt++;
    if (acc) begin
      exp_q.push_back('{tx: 1'b0, bsy: 1'b1, mux: 2'b00});
      for (int i = 0; i < 8; i++) exp_q.push_back('{tx: pdata[i], bsy: 1'b1, mux: 2'b10});
      if (par_en) exp_q.push_back('{tx: (^pdata) ^ par_typ, bsy: 1'b1, mux: 2'b11});
      exp_q.push_back('{tx: 1'b1, bsy: 1'b1, mux: 2'b01});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input int n,
                           output logic [15:0] bits, output int nb);
    dv = 1'b1; pdata = d; par_en = pe; par_typ = pt;
    cycle();
    dv = 1'b0; pdata = ~d; par_en = ~pe; par_typ = ~pt;
    bits = '0;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      bits = {bits[14:0], last_tx};
      nb += int'(last_busy);
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk1("rst_tx_out", tx_out, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chkv("rst_mux_sel", 16'(mux_sel), 16'h1);
    chk1("rst_ser_en", ser_en, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    exp_q.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] bits;
    int          nb;
    logic        pending;

    #12;
    chk1("init_tx_out", tx_out, 1'b1);
    chk1("init_busy", busy, 1'b0);
    chkv("init_mux_sel", 16'(mux_sel), 16'h1);
    chk1("init_frame_err", frame_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    run_frame(8'hA5, 1'b1, 1'b0, 12, bits, nb);
    chkv("t1_even_trace", bits, 16'b0000_0101_0010_1011);
    chkv("t1_busy_cycles", 16'(nb), 16'd11);

    run_frame(8'hA5, 1'b1, 1'b1, 12, bits, nb);
    chkv("t2_odd_trace", bits, 16'b0000_0101_0010_1111);

    par_cnt = 0;
    run_frame(8'hFF, 1'b0, 1'b0, 12, bits, nb);
    chkv("t3_nopar_trace", bits, 16'b0000_0111_1111_1111);
    chkv("t3_busy_cycles", 16'(nb), 16'd10);
    chkv("t3_parity_cycles", 16'(par_cnt), 16'd0);

    sen_cnt = 0;
    nb = 0;
    dv = 1'b1; pdata = 8'h01; par_en = 1'b1; par_typ = 1'b0;
    cycle();
    pdata = 8'h80;
    for (int i = 0; i < 23; i++) begin
      if (i == 11) dv = 1'b0;
      cycle();
      nb += int'(last_busy);
    end
    chkv("t4_ser_en_pulses", 16'(sen_cnt), 16'd2);
    chkv("t4_busy_no_gap", 16'(nb), 16'd22);

    dv = 1'b1; pdata = 8'h55; par_en = 1'b1; par_typ = 1'b0;
    cycle();
    dv = 1'b0;
    repeat (4) cycle();
    async_reset();
    run_frame(8'h3C, 1'b1, 1'b0, 12, bits, nb);
    chkv("t5_after_reset_trace", bits, 16'b0000_0001_1110_0011);

    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1'b1;
        pdata = 8'($urandom);
        par_en = 1'($urandom);
        par_typ = 1'($urandom);
      end else if (!pending) begin
        pdata = 8'($urandom);
        par_en = 1'($urandom);
        par_typ = 1'($urandom);
      end
      dv = pending;
      cycle();
      if (last_acc) pending = 1'b0;
    end
    dv = 1'b0;
    repeat (14) cycle();

    d5_cnt = 0;
    b5_cnt = 0;
    bits = '0;
    dv5 = 1'b1; pdata5 = 5'h13; par_en5 = 1'b1; par_typ5 = 1'b0;
    cycle();
    dv5 = 1'b0; pdata5 = 5'h0C;
    for (int i = 0; i < 9; i++) begin
      cycle();
      bits = {bits[14:0], last5_tx};
    end
    chkv("w5_trace", bits, 16'b0000_0000_1100_1111);
    chkv("w5_data_cycles", 16'(d5_cnt), 16'd5);
    chkv("w5_busy_cycles", 16'(b5_cnt), 16'd8);

    dv = 1'b1; pdata = 8'h6B; par_en = 1'b1; par_typ = 1'b1;
    cycle();
    dv = 1'b0;
    force_done = 1'b1;
    cycle();
    force_done = 1'b0;
    repeat (13) cycle();
    chk1("t6_frame_err_sticky", frame_err, 1'b1);
    async_reset();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
